// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply/divide unit.
// Booth radix-2 multiply and restoring divide, each taking 32 cycles,
// with results in HI/LO registers. Divide by zero is flagged and
// leaves HI/LO untouched.
module mult_div_unit (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        op_start,
   input  logic        op_sel,
   input  logic [31:0] data_a,
   input  logic [31:0] data_b,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic        busy,
   output logic        done,
   output logic        div_zero
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_MULT   = 3'd1,
      S_DIV    = 3'd2,
      S_FIX    = 3'd3,
      S_FINISH = 3'd4
   } state_t;

   state_t      r_state;
   logic [5:0]  r_cnt;
   // Multiply layout: {A[64:33], Q[32:1], q-1[0]}.
   // Divide layout:   {R[64:32], Q[31:0]}.
   logic [64:0] r_acc;
   logic [31:0] r_opnd;     // multiplicand, or divisor magnitude
   logic        r_is_div;
   logic        r_neg_q;
   logic        r_neg_r;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_busy;
   logic        r_done;
   logic        r_div_zero;

   logic [32:0] w_a_ext;
   logic [32:0] w_m_ext;
   logic [32:0] w_booth_sum;
   logic [64:0] w_booth_next;
   logic [32:0] w_shift;
   logic [33:0] w_trial;
   logic [64:0] w_div_next;

   // Two's-complement magnitude; -2^31 maps to 0x80000000 as unsigned.
   function automatic logic [31:0] f_abs(input logic [31:0] v);
      f_abs = v[31] ? (~v + 32'd1) : v;
   endfunction

   // Two's-complement negation.
   function automatic logic [31:0] f_neg(input logic [31:0] v);
      f_neg = ~v + 32'd1;
   endfunction

   // One Booth step: add/subtract the multiplicand on a 33-bit accumulator
   // (so a -2^31 multiplicand cannot overflow), then shift right arithmetically.
   always_comb begin
      w_a_ext = {r_acc[64], r_acc[64:33]};
      w_m_ext = {r_opnd[31], r_opnd};
      case (r_acc[1:0])
         2'b01:   w_booth_sum = w_a_ext + w_m_ext;
         2'b10:   w_booth_sum = w_a_ext - w_m_ext;
         default: w_booth_sum = w_a_ext;
      endcase
      w_booth_next = {w_booth_sum, r_acc[32:1]};
   end

   // One restoring-division step: shift the next dividend bit into the
   // remainder and keep the trial difference when it is not negative.
   always_comb begin
      w_shift = {r_acc[63:32], r_acc[31]};
      w_trial = {1'b0, w_shift} - {2'b00, r_opnd};
      if (!w_trial[33]) begin
         w_div_next = {w_trial[32:0], r_acc[30:0], 1'b1};
      end else begin
         w_div_next = {w_shift, r_acc[30:0], 1'b0};
      end
   end

   // Control FSM, iteration datapath and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= 6'd0;
         r_acc      <= 65'd0;
         r_opnd     <= 32'd0;
         r_is_div   <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_hi       <= 32'd0;
         r_lo       <= 32'd0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (op_start) begin
                  r_cnt    <= 6'd0;
                  r_is_div <= op_sel;
                  r_neg_q  <= data_a[31] ^ data_b[31];
                  r_neg_r  <= data_a[31];
                  if (op_sel && (data_b == 32'd0)) begin
                     r_div_zero <= 1'b1;
                     r_busy     <= 1'b0;
                     r_state    <= S_FINISH;
                  end else if (op_sel) begin
                     r_div_zero <= 1'b0;
                     r_acc      <= {33'd0, f_abs(data_a)};
                     r_opnd     <= f_abs(data_b);
                     r_busy     <= 1'b1;
                     r_state    <= S_DIV;
                  end else begin
                     r_div_zero <= 1'b0;
                     r_acc      <= {32'd0, data_b, 1'b0};
                     r_opnd     <= data_a;
                     r_busy     <= 1'b1;
                     r_state    <= S_MULT;
                  end
               end
            end
            S_MULT: begin
               r_done <= 1'b0;
               r_acc  <= w_booth_next;
               r_cnt  <= r_cnt + 6'd1;
               if (r_cnt == 6'd31) begin
                  r_state <= S_FIX;
               end
            end
            S_DIV: begin
               r_done <= 1'b0;
               r_acc  <= w_div_next;
               r_cnt  <= r_cnt + 6'd1;
               if (r_cnt == 6'd31) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_done <= 1'b0;
               if (r_is_div) begin
                  r_lo <= r_neg_q ? f_neg(r_acc[31:0])  : r_acc[31:0];
                  r_hi <= r_neg_r ? f_neg(r_acc[63:32]) : r_acc[63:32];
               end else begin
                  r_hi <= r_acc[64:33];
                  r_lo <= r_acc[32:1];
               end
               r_busy  <= 1'b0;
               r_state <= S_FINISH;
            end
            S_FINISH: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign hi_out   = r_hi;
   assign lo_out   = r_lo;
   assign busy     = r_busy;
   assign done     = r_done;
   assign div_zero = r_div_zero;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed vectors, expected results queued
// by the stimulus and checked by an independent monitor on each done pulse.
module tb_mult_div_unit;

   logic        clk;
   logic        reset_n;
   logic        op_start;
   logic        op_sel;
   logic [31:0] data_a;
   logic [31:0] data_b;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        busy;
   logic        done;
   logic        div_zero;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          start;
      int          lat;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [31:0] prev_hi  = 32'd0;
   logic [31:0] prev_lo  = 32'd0;

   mult_div_unit dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .op_start (op_start),
      .op_sel   (op_sel),
      .data_a   (data_a),
      .data_b   (data_b),
      .hi_out   (hi_out),
      .lo_out   (lo_out),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // rising-edge counter used for latency measurement
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: every done pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (reset_n && done) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("hi_out", {32'd0, hi_out}, {32'd0, e.hi});
            chk("lo_out", {32'd0, lo_out}, {32'd0, e.lo});
            chk("div_zero_at_done", {63'd0, div_zero}, {63'd0, e.dz});
            chk("done_latency", 64'(cyc - e.start), 64'(e.lat));
         end
      end
   end

   // issue one operation, optionally poke op_start mid-flight, wait for done
   task automatic run_op(input logic sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el,
                         input logic edz, input int inject);
      int   lat_exp;
      int   busy_cnt;
      logic hold_ok;
      logic seen;
      exp_t e;
      lat_exp  = (sel && (b == 32'd0)) ? 1 : 34;
      busy_cnt = 0;
      hold_ok  = 1'b1;
      seen     = 1'b0;
      @(negedge clk);
      op_start = 1'b1;
      op_sel   = sel;
      data_a   = a;
      data_b   = b;
      @(posedge clk);
      #1;
      op_start = 1'b0;
      op_sel   = ~sel;
      data_a   = 32'hDEAD_BEEF;
      data_b   = 32'd0;
      e.hi = eh; e.lo = el; e.dz = edz; e.start = cyc; e.lat = lat_exp;
      sb_q.push_back(e);
      chk("div_zero_after_start", {63'd0, div_zero}, {63'd0, edz});
      for (int k = 0; k < 60 && !seen; k++) begin
         @(negedge clk);
         if (k == inject) begin
            op_start = 1'b1;
            op_sel   = 1'b0;
            data_a   = 32'd3;
            data_b   = 32'd5;
         end else begin
            op_start = 1'b0;
         end
         if (busy) begin
            busy_cnt++;
            if (hi_out !== prev_hi || lo_out !== prev_lo) hold_ok = 1'b0;
         end
         if (done) seen = 1'b1;
      end
      op_start = 1'b0;
      chk("done_seen", {63'd0, seen}, 64'd1);
      chk("busy_cycles", 64'(busy_cnt), 64'((lat_exp == 34) ? 33 : 0));
      chk("hilo_hold_while_busy", {63'd0, hold_ok}, 64'd1);
      prev_hi = eh;
      prev_lo = el;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      reset_n  = 1'b0;
      op_start = 1'b0;
      op_sel   = 1'b0;
      data_a   = 32'd0;
      data_b   = 32'd0;
      repeat (3) @(negedge clk);
      chk("reset_hi", {32'd0, hi_out}, 64'd0);
      chk("reset_lo", {32'd0, lo_out}, 64'd0);
      chk("reset_flags", {61'd0, busy, done, div_zero}, 64'd0);
      reset_n = 1'b1;

      // multiply
      run_op(1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, -1);
      run_op(1'b0, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, -1);
      run_op(1'b0, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, -1);
      run_op(1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, -1);
      // divide
      run_op(1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, -1);
      run_op(1'b1, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, -1);
      run_op(1'b1, 32'h0000_0451,  32'h0000_0020, 32'h0000_0011, 32'h0000_0022, 1'b0, -1);
      // divide by zero keeps 0x11/0x22
      run_op(1'b1, 32'd5,          32'd0,         32'h0000_0011, 32'h0000_0022, 1'b1, -1);
      // overflow case, with an ignored op_start in the middle
      run_op(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 10);
      run_op(1'b1, 32'd100,        32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0, -1);
      run_op(1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E, 1'b0, -1);

      // reset in the middle of a multiply
      @(negedge clk);
      op_start = 1'b1;
      op_sel   = 1'b0;
      data_a   = 32'h0000_1234;
      data_b   = 32'h0000_5678;
      @(posedge clk);
      #1;
      op_start = 1'b0;
      repeat (15) @(negedge clk);
      chk("busy_before_abort", {63'd0, busy}, 64'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("abort_hi", {32'd0, hi_out}, 64'd0);
      chk("abort_lo", {32'd0, lo_out}, 64'd0);
      chk("abort_flags", {61'd0, busy, done, div_zero}, 64'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      prev_hi = 32'd0;
      prev_lo = 32'd0;
      run_op(1'b0, 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C, 1'b0, -1);

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
